// File: rtl/msp430_dmem_arbiter_pkg.sv
// Shared types and constants for the MSP430 data-memory arbiter.
//   owner_t     : requester identity, also used to tag an outstanding read
//   arb_state_t : arbiter FSM states (free arbitration or locked to one master)
//   WEN_READ    : byte write-enable pattern meaning "read" (active low)
//   lock_state  : maps a requester to the FSM state that locks the bus to it
package msp430_arb_pkg;

   typedef enum logic [1:0] {
      OWN_DBG  = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2,
      OWN_NONE = 2'd3
   } owner_t;

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      LOCK_DBG = 2'd1,
      LOCK_CPU = 2'd2,
      LOCK_DMA = 2'd3
   } arb_state_t;

   localparam logic [1:0] WEN_READ = 2'b11;

   function automatic arb_state_t lock_state(owner_t o);
      case (o)
         OWN_DBG: return LOCK_DBG;
         OWN_CPU: return LOCK_CPU;
         OWN_DMA: return LOCK_DMA;
         default: return ARB;
      endcase
   endfunction

endpackage

// File: rtl/msp430_dmem_arbiter_if.sv
// Bundle of every signal between the three data-memory masters (dbg, cpu,
// dma), the arbiter and the single-port data memory.
//   slave  : arbiter view (takes requests and dmem_dout, drives grants,
//            rvalids, rdata and the dmem_* request port)
//   master : environment view (requesters and memory), the mirror image
interface msp430_dmem_arbiter_if #(
   parameter int DW       = 16,
   parameter int DMEM_MSB = 16
);
   logic                dbg_freeze;

   logic                dbg_req,  cpu_req,  dma_req;
   logic                dbg_lock, cpu_lock, dma_lock;
   logic [DMEM_MSB:0]   dbg_addr, cpu_addr, dma_addr;
   logic [1:0]          dbg_wen,  cpu_wen,  dma_wen;
   logic [DW-1:0]       dbg_din,  cpu_din,  dma_din;

   logic                dbg_gnt,    cpu_gnt,    dma_gnt;
   logic                dbg_rvalid, cpu_rvalid, dma_rvalid;
   logic [DW-1:0]       rdata;

   logic [DMEM_MSB:0]   dmem_addr;
   logic                dmem_cen;
   logic [1:0]          dmem_wen;
   logic [DW-1:0]       dmem_din;
   logic [DW-1:0]       dmem_dout;

   modport slave (
      input  dbg_freeze,
      input  dbg_req, cpu_req, dma_req,
      input  dbg_lock, cpu_lock, dma_lock,
      input  dbg_addr, cpu_addr, dma_addr,
      input  dbg_wen, cpu_wen, dma_wen,
      input  dbg_din, cpu_din, dma_din,
      output dbg_gnt, cpu_gnt, dma_gnt,
      output dbg_rvalid, cpu_rvalid, dma_rvalid,
      output rdata,
      output dmem_addr, dmem_cen, dmem_wen, dmem_din,
      input  dmem_dout
   );

   modport master (
      output dbg_freeze,
      output dbg_req, cpu_req, dma_req,
      output dbg_lock, cpu_lock, dma_lock,
      output dbg_addr, cpu_addr, dma_addr,
      output dbg_wen, cpu_wen, dma_wen,
      output dbg_din, cpu_din, dma_din,
      input  dbg_gnt, cpu_gnt, dma_gnt,
      input  dbg_rvalid, cpu_rvalid, dma_rvalid,
      input  rdata,
      input  dmem_addr, dmem_cen, dmem_wen, dmem_din,
      output dmem_dout
   );

endinterface

// File: rtl/msp430_dmem_arbiter_starve_cnt.sv
// Saturating starvation counter for the dma requester.
//   mclk, puc_rst : clock and synchronous active-high reset
//   inc           : dma was eligible but lost arbitration this cycle
//   clr           : dma was granted or stopped requesting
//   hold          : freeze the count (debug freeze)
//   promote       : count has reached STARVE_MAX (never set if STARVE_MAX=0)
module msp430_arb_starve_cnt #(
   parameter int STARVE_MAX = 8
) (
   input  logic mclk,
   input  logic puc_rst,
   input  logic inc,
   input  logic clr,
   input  logic hold,
   output logic promote
);
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

   logic [CW-1:0] cnt;

   // A dropped request clears even under freeze, so a stale count can never
   // promote a fresh dma request the moment the freeze lifts.
   always_ff @(posedge mclk) begin
      if (puc_rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (hold)
         cnt <= cnt;
      else if (inc && (cnt < MAX))
         cnt <= cnt + CW'(1);
   end

   assign promote = (STARVE_MAX != 0) && (cnt == MAX);

endmodule

// File: rtl/msp430_dmem_arbiter.sv
// Data-memory arbiter: shares the single-port dmem between the debug unit,
// the CPU execution unit and a DMA engine.
//   mclk, puc_rst : clock and synchronous active-high reset
//   bus (slave)   : per-master req/lock/addr/wen/din in, gnt/rvalid out,
//                   shared rdata, and the dmem_* memory port
// Fixed priority dbg > cpu > dma; a starved dma is promoted to the top; a
// master may lock the bus across accesses for read-modify-write.
module msp430_dmem_arbiter
   import msp430_arb_pkg::*;
#(
   parameter int DW         = 16,
   parameter int DMEM_MSB   = 16,
   parameter int STARVE_MAX = 8
) (
   input  logic                  mclk,
   input  logic                  puc_rst,
   msp430_dmem_arbiter_if.slave  bus
);
   localparam int AW = DMEM_MSB + 1;

   // Per-master views, indexed by owner_t
   logic [2:0]               req, lck, gnt;
   logic [2:0][AW-1:0]       addr;
   logic [2:0][1:0]          wen;
   logic [2:0][DW-1:0]       din;

   assign req  = {bus.dma_req,  bus.cpu_req,  bus.dbg_req};
   assign lck  = {bus.dma_lock, bus.cpu_lock, bus.dbg_lock};
   assign addr = {bus.dma_addr, bus.cpu_addr, bus.dbg_addr};
   assign wen  = {bus.dma_wen,  bus.cpu_wen,  bus.dbg_wen};
   assign din  = {bus.dma_din,  bus.cpu_din,  bus.dbg_din};

   arb_state_t     state, state_nxt;
   owner_t         own;
   owner_t         rd_owner;
   logic           rd_pend;
   logic           dma_elig, promote;
   logic           starve_inc, starve_clr;
   logic [AW-1:0]  mem_addr;
   logic [1:0]     mem_wen;
   logic [DW-1:0]  mem_din;

   assign dma_elig = bus.dma_req & ~bus.dbg_freeze;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge mclk) begin
      if (puc_rst) state <= ARB;
      else         state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // A lock taken with req=0 never matters: no grant, so no transition.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ARB:      if (own != OWN_NONE && lck[own]) state_nxt = lock_state(own);
         LOCK_DBG: if (!req[OWN_DBG] || !lck[OWN_DBG]) state_nxt = ARB;
         LOCK_CPU: if (!req[OWN_CPU] || !lck[OWN_CPU]) state_nxt = ARB;
         // dma_elig drops on dbg_freeze, releasing the lock that same cycle
         LOCK_DMA: if (!dma_elig || !lck[OWN_DMA]) state_nxt = ARB;
         default:  state_nxt = ARB;
      endcase
   end

   // ---------------- FSM: outputs (winner and memory port) ----------------
   always_comb begin
      own = OWN_NONE;
      if (!puc_rst) begin
         unique case (state)
            ARB: begin
               if (promote && dma_elig) own = OWN_DMA;
               else if (req[OWN_DBG])   own = OWN_DBG;
               else if (req[OWN_CPU])   own = OWN_CPU;
               else if (dma_elig)       own = OWN_DMA;
            end
            LOCK_DBG: if (req[OWN_DBG]) own = OWN_DBG;
            LOCK_CPU: if (req[OWN_CPU]) own = OWN_CPU;
            LOCK_DMA: if (dma_elig)     own = OWN_DMA;
            default:  own = OWN_NONE;
         endcase
      end

      gnt      = '0;
      mem_addr = '0;
      mem_wen  = WEN_READ;
      mem_din  = '0;
      if (own != OWN_NONE) begin
         gnt[own] = 1'b1;
         mem_addr = addr[own];
         mem_wen  = wen[own];
         mem_din  = din[own];
      end
   end

   assign bus.dbg_gnt   = gnt[OWN_DBG];
   assign bus.cpu_gnt   = gnt[OWN_CPU];
   assign bus.dma_gnt   = gnt[OWN_DMA];
   assign bus.dmem_cen  = (own == OWN_NONE);
   assign bus.dmem_addr = mem_addr;
   assign bus.dmem_wen  = mem_wen;
   assign bus.dmem_din  = mem_din;

   // ---------------- read return tracking ----------------
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         rd_pend  <= 1'b0;
         rd_owner <= OWN_NONE;
      end else begin
         rd_pend  <= (own != OWN_NONE) && (mem_wen == WEN_READ);
         rd_owner <= own;
      end
   end

   // Gated with reset so a read issued just before reset never returns.
   assign bus.dbg_rvalid = ~puc_rst & rd_pend & (rd_owner == OWN_DBG);
   assign bus.cpu_rvalid = ~puc_rst & rd_pend & (rd_owner == OWN_CPU);
   assign bus.dma_rvalid = ~puc_rst & rd_pend & (rd_owner == OWN_DMA);
   assign bus.rdata      = bus.dmem_dout;

   // ---------------- dma starvation escalator ----------------
   assign starve_inc = dma_elig & ~gnt[OWN_DMA];
   assign starve_clr = ~bus.dma_req | gnt[OWN_DMA];

   msp430_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .inc     (starve_inc),
      .clr     (starve_clr),
      .hold    (bus.dbg_freeze),
      .promote (promote)
   );

endmodule
